// File: rtl/encode_msg_seq_pkg.sv
// Shared Kyber constants and state type for the message encoder.
// The optional range check in encode_msg_seq is enabled by ENCODE_MSG_RANGE_CHK_EN.
package encode_msg_seq_pkg;

  localparam int KYBER_N       = 256;
  localparam int KYBER_Q       = 3329;
  localparam int KYBER_R_WIDTH = 12;

  // Compress_q(c,1) is 1 exactly on the closed interval [LO, HI]
  localparam int COMPRESS1_LO  = 833;
  localparam int COMPRESS1_HI  = 2496;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_e;

endpackage

// File: rtl/encode_msg_seq_compress1.sv
// compress1: combinational Compress_q(c,1) for one coefficient.
// Values at or above q are not special-cased; they simply fall outside the window.
module compress1
  import encode_msg_seq_pkg::*;
#(
  parameter int COEFF_W = KYBER_R_WIDTH
) (
  input  logic [COEFF_W-1:0] coeff,
  output logic               coeff_bit
);

  assign coeff_bit = (coeff >= COEFF_W'(COMPRESS1_LO)) &&
                     (coeff <= COEFF_W'(COMPRESS1_HI));

endmodule

// File: rtl/encode_msg_seq.sv
// encode_msg_seq: collects N coefficients in index order, compresses each to one
// bit and presents the N-bit message with a valid/ready handoff.
// Define ENCODE_MSG_RANGE_CHK_EN to add a sticky err output for coefficients >= q.
module encode_msg_seq
  import encode_msg_seq_pkg::*;
#(
  parameter int N       = KYBER_N,
  parameter int COEFF_W = KYBER_R_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] coeff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       msg
`ifdef ENCODE_MSG_RANGE_CHK_EN
  ,
  output logic               err
`endif
);

  localparam int IDX_W = $clog2(N);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             coeff_bit;
  logic             accept;
  logic             last;

  compress1 #(.COEFF_W(COEFF_W)) u_compress1 (
    .coeff     (coeff),
    .coeff_bit (coeff_bit)
  );

  // Acceptance is decoded from state directly so in_ready never feeds back into it
  assign accept = in_valid && (state == COLLECT);
  assign last   = (idx == IDX_W'(N - 1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs, purely from state plus the relevant strobe
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Write the compressed bit at idx and advance; idx wraps to 0 on the last coefficient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      // NOTE: msg is cleared on reset so a partial message can never leak into the next one.
      msg <= '0;
    end else if (accept) begin
      msg[idx] <= coeff_bit;
      idx      <= last ? '0 : idx + IDX_W'(1);
    end
  end

`ifdef ENCODE_MSG_RANGE_CHK_EN
  // Sticky range flag: set on any accepted coefficient >= q, cleared at handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      err <= 1'b0;
    else if ((state == DONE) && out_ready)        err <= 1'b0;
    else if (accept && (coeff >= COEFF_W'(KYBER_Q))) err <= 1'b1;
  end
`endif

endmodule
